card_deck_dealer: RTL and testbench

- Card source upstream of the blackjack game FSM.
- Models one 52-card deck and serves one card per draw request, with no card repeated until the next shuffle.
- Each card is a rank value 1..13 (1=Ace, 11=J, 12=Q, 13=K) plus a suit symbol 0..3, matching the FSM's 4-bit value and 2-bit symbol card arrays.
- Pseudo-random card selection comes from a free-running LFSR plus a used-card bitmap with linear probing.

---
 rtl/card_pkg.sv | 41 ++++
 rtl/card_deck_dealer_if.sv | 27 ++
 rtl/card_deck_dealer_lfsr16.sv | 31 +++
 rtl/card_deck_dealer.sv | 130 +++++++++++++
 tb/tb_card_deck_dealer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// Shared card definitions for the dealer and the blackjack game FSM.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;

    typedef logic [3:0] card_value_t;
    typedef logic [1:0] card_symbol_t;
    typedef logic [5:0] card_idx_t;

    typedef struct packed {
        card_value_t  value;
        card_symbol_t symbol;
    } card_t;

    typedef enum logic {
        ST_IDLE,
        ST_PROBE
    } dealer_state_t;

    // Suit-major layout: idx 0..12 are suit 0, 13..25 suit 1, and so on.
    function automatic card_t idx_to_card(card_idx_t idx);
        card_t c;
        if (idx < 6'd13) begin
            c.symbol = 2'd0;
            c.value  = 4'(idx + 6'd1);
        end else if (idx < 6'd26) begin
            c.symbol = 2'd1;
            c.value  = 4'(idx - 6'd12);
        end else if (idx < 6'd39) begin
            c.symbol = 2'd2;
            c.value  = 4'(idx - 6'd25);
        end else begin
            c.symbol = 2'd3;
            c.value  = 4'(idx - 6'd38);
        end
        return c;
    endfunction

endpackage

// File: rtl/card_deck_dealer_if.sv
// Request/response bundle between the game controller and the card dealer.
interface card_deck_dealer_if;
    import card_pkg::*;

    logic         shuffle;
    logic         draw_req;
    logic         busy;
    logic         card_valid;
    card_value_t  card_value;
    card_symbol_t card_symbol;
    logic [5:0]   cards_left;
    logic         deck_empty;
    logic         draw_err;

    modport master (
        output shuffle, draw_req,
        input  busy, card_valid, card_value, card_symbol,
               cards_left, deck_empty, draw_err
    );

    modport slave (
        input  shuffle, draw_req,
        output busy, card_valid, card_value, card_symbol,
               cards_left, deck_empty, draw_err
    );

endinterface

// File: rtl/card_deck_dealer_lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q >> 1;
        if (q_q[0]) begin
            q_d = (q_q >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_deck_dealer.sv
// 52-card deck: picks a start slot, then linearly probes the used bitmap
// for the next card still in the deck.
module card_deck_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter bit          RANDOM = 1'b1
) (
    input logic               clk,
    input logic               rst,
    card_deck_dealer_if.slave bus
);

    dealer_state_t state_q, state_d;
    logic [51:0]   used_q, used_d;
    logic [5:0]    cards_left_q, cards_left_d;
    card_idx_t     idx_q, idx_d;
    card_value_t   value_q, value_d;
    card_symbol_t  symbol_q, symbol_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          empty_q, empty_d;

    logic [15:0]   lfsr_q;
    card_idx_t     start_idx;
    card_t         probe_card;

    lfsr16 #(
        .SEED (SEED),
        .TAPS (16'hB400)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Fold 52..63 back onto 0..11 so the start slot is always a real card.
    always_comb begin
        start_idx = 6'd0;
        if (RANDOM) begin
            start_idx = lfsr_q[5:0];
            if (lfsr_q[5:0] >= 6'd52) begin
                start_idx = lfsr_q[5:0] - 6'd52;
            end
        end
    end

    assign probe_card = idx_to_card(idx_q);

    always_comb begin
        state_d      = state_q;
        used_d       = used_q;
        cards_left_d = cards_left_q;
        idx_d        = idx_q;
        value_d      = value_q;
        symbol_d     = symbol_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.shuffle) begin
                    used_d       = '0;
                    cards_left_d = 6'd52;
                end else if (bus.draw_req) begin
                    if (cards_left_q == 6'd0) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = start_idx;
                        state_d = ST_PROBE;
                    end
                end
            end
            ST_PROBE: begin
                if (bus.shuffle) begin
                    used_d       = '0;
                    cards_left_d = 6'd52;
                    state_d      = ST_IDLE;
                end else if (!used_q[idx_q]) begin
                    used_d[idx_q] = 1'b1;
                    cards_left_d  = cards_left_q - 6'd1;
                    value_d       = probe_card.value;
                    symbol_d      = probe_card.symbol;
                    valid_d       = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    idx_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        empty_d = (cards_left_d == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            used_q       <= '0;
            cards_left_q <= 6'd52;
            idx_q        <= '0;
            value_q      <= '0;
            symbol_q     <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            empty_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            used_q       <= used_d;
            cards_left_q <= cards_left_d;
            idx_q        <= idx_d;
            value_q      <= value_d;
            symbol_q     <= symbol_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            empty_q      <= empty_d;
        end
    end

    assign bus.busy        = (state_q == ST_PROBE);
    assign bus.card_valid  = valid_q;
    assign bus.card_value  = value_q;
    assign bus.card_symbol = symbol_q;
    assign bus.cards_left  = cards_left_q;
    assign bus.deck_empty  = empty_q;
    assign bus.draw_err    = err_q;

endmodule

// File: tb/tb_card_deck_dealer.sv
// Scoreboard bench: an in-order dealer (RANDOM=0) and a random dealer (RANDOM=1).
module tb_card_deck_dealer;
    import card_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int value;
        int symbol;
        int issue;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    card_deck_dealer_if bus0 ();
    card_deck_dealer_if bus1 ();

    card_deck_dealer #(.SEED(SEED), .RANDOM(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    card_deck_dealer #(.SEED(SEED), .RANDOM(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0;
    exp_t        e1;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          pops0 = 0;
    int          pops1 = 0;
    int          gotv0[52];
    int          gots0[52];
    int          lat0[52];
    logic [51:0] used0;
    logic [51:0] used1;
    logic [51:0] seen1;
    int          left0;
    int          left1;
    logic [15:0] m_lfsr;

    // Reference LFSR and cycle counter, independent of the DUTs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_lfsr <= SEED;
        end else if (m_lfsr[0]) begin
            m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        end else begin
            m_lfsr <= m_lfsr >> 1;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pop expectations whenever either dealer presents a card.
    always @(negedge clk) begin
        if (bus0.card_valid === 1'b1) begin
            checkOutput("det_card_pending", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                checkOutput("det_value", int'(bus0.card_value), e0.value);
                checkOutput("det_symbol", int'(bus0.card_symbol), e0.symbol);
                checkOutput("det_latency", cyc - e0.issue, e0.due - e0.issue);
                if (pops0 < 52) begin
                    gotv0[pops0] = int'(bus0.card_value);
                    gots0[pops0] = int'(bus0.card_symbol);
                    lat0[pops0]  = cyc - e0.issue;
                end
            end
            pops0++;
        end
        if (bus1.card_valid === 1'b1) begin
            checkOutput("rand_card_pending", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                checkOutput("rand_value", int'(bus1.card_value), e1.value);
                checkOutput("rand_symbol", int'(bus1.card_symbol), e1.symbol);
                checkOutput("rand_latency", cyc - e1.issue, e1.due - e1.issue);
            end
            checkOutput("rand_value_range",
                        int'(bus1.card_value >= 4'd1 && bus1.card_value <= 4'd13), 1);
            if (bus1.card_value >= 4'd1 && bus1.card_value <= 4'd13) begin
                checkOutput("rand_unique",
                            int'(seen1[int'(bus1.card_symbol) * 13 + int'(bus1.card_value) - 1]), 0);
                seen1[int'(bus1.card_symbol) * 13 + int'(bus1.card_value) - 1] = 1'b1;
            end
            pops1++;
        end
    end

    task automatic waitPop0(input int tgt);
        for (int i = 0; i < 70 && pops0 < tgt; i++) tick();
        checkOutput("det_card_arrived", pops0, tgt);
    endtask

    task automatic waitPop1(input int tgt);
        for (int i = 0; i < 70 && pops1 < tgt; i++) tick();
        checkOutput("rand_card_arrived", pops1, tgt);
    endtask

    task automatic applyStimulus(input bit rnd);
        int idx;
        int k;
        int tgt;
        if (rnd) begin
            idx = int'(m_lfsr[5:0]);
            if (idx >= 52) idx -= 52;
        end else begin
            idx = 0;
        end
        k = 0;
        while ((rnd ? used1[idx] : used0[idx]) && k < 52) begin
            idx = (idx == 51) ? 0 : idx + 1;
            k++;
        end
        if (rnd) begin
            q1.push_back('{idx % 13 + 1, idx / 13, cyc, cyc + 2 + k});
            used1[idx] = 1'b1;
            left1--;
            tgt = pops1 + 1;
            bus1.draw_req = 1'b1;
            tick();
            bus1.draw_req = 1'b0;
            waitPop1(tgt);
            checkOutput("rand_cards_left", int'(bus1.cards_left), left1);
        end else begin
            q0.push_back('{idx % 13 + 1, idx / 13, cyc, cyc + 2 + k});
            used0[idx] = 1'b1;
            left0--;
            tgt = pops0 + 1;
            bus0.draw_req = 1'b1;
            tick();
            bus0.draw_req = 1'b0;
            waitPop0(tgt);
            checkOutput("det_cards_left", int'(bus0.cards_left), left0);
            checkOutput("det_deck_empty", int'(bus0.deck_empty), int'(left0 == 0));
        end
    endtask

    initial begin
        int p;
        rst = 1'b1;
        bus0.shuffle = 1'b0;
        bus0.draw_req = 1'b0;
        bus1.shuffle = 1'b0;
        bus1.draw_req = 1'b0;
        used0 = '0;
        used1 = '0;
        seen1 = '0;
        left0 = 52;
        left1 = 52;

        tick();
        tick();
        checkOutput("rst_cards_left", int'(bus0.cards_left), 52);
        checkOutput("rst_deck_empty", int'(bus0.deck_empty), 0);
        checkOutput("rst_busy", int'(bus0.busy), 0);
        checkOutput("rst_card_valid", int'(bus0.card_valid), 0);
        checkOutput("rst_card_value", int'(bus0.card_value), 0);
        checkOutput("rst_card_symbol", int'(bus0.card_symbol), 0);
        checkOutput("rst_draw_err", int'(bus0.draw_err), 0);
        checkOutput("rst_rand_cards_left", int'(bus1.cards_left), 52);
        rst = 1'b0;
        tick();

        $display("[TB] in-order deal of 52 cards");
        for (int n = 0; n < 52; n++) applyStimulus(1'b0);
        checkOutput("draw1_value", gotv0[0], 1);
        checkOutput("draw1_symbol", gots0[0], 0);
        checkOutput("draw1_latency", lat0[0], 2);
        checkOutput("draw2_value", gotv0[1], 2);
        checkOutput("draw2_latency", lat0[1], 3);
        checkOutput("draw3_value", gotv0[2], 3);
        checkOutput("draw3_symbol", gots0[2], 0);
        checkOutput("draw3_latency", lat0[2], 4);
        checkOutput("draw14_value", gotv0[13], 1);
        checkOutput("draw14_symbol", gots0[13], 1);
        checkOutput("draw52_value", gotv0[51], 13);
        checkOutput("draw52_symbol", gots0[51], 3);
        checkOutput("draw52_latency", lat0[51], 53);
        checkOutput("empty_cards_left", int'(bus0.cards_left), 0);
        checkOutput("empty_deck_empty", int'(bus0.deck_empty), 1);

        $display("[TB] draw on empty deck");
        p = pops0;
        bus0.draw_req = 1'b1;
        tick();
        bus0.draw_req = 1'b0;
        checkOutput("empty_draw_err", int'(bus0.draw_err), 1);
        checkOutput("empty_busy", int'(bus0.busy), 0);
        tick();
        checkOutput("empty_draw_err_pulse", int'(bus0.draw_err), 0);
        checkOutput("empty_cards_left_hold", int'(bus0.cards_left), 0);
        tick();
        tick();
        checkOutput("empty_no_card", pops0, p);

        $display("[TB] shuffle in idle");
        bus0.shuffle = 1'b1;
        tick();
        bus0.shuffle = 1'b0;
        checkOutput("shuf_cards_left", int'(bus0.cards_left), 52);
        checkOutput("shuf_deck_empty", int'(bus0.deck_empty), 0);
        used0 = '0;
        left0 = 52;

        p = pops0;
        bus0.shuffle = 1'b1;
        bus0.draw_req = 1'b1;
        tick();
        bus0.shuffle = 1'b0;
        bus0.draw_req = 1'b0;
        checkOutput("shuf_draw_busy", int'(bus0.busy), 0);
        tick();
        tick();
        tick();
        checkOutput("shuf_draw_no_card", pops0, p);
        checkOutput("shuf_draw_cards_left", int'(bus0.cards_left), 52);

        $display("[TB] shuffle after 10 draws");
        for (int n = 0; n < 10; n++) applyStimulus(1'b0);
        bus0.shuffle = 1'b1;
        tick();
        bus0.shuffle = 1'b0;
        checkOutput("shuf10_cards_left", int'(bus0.cards_left), 52);
        used0 = '0;
        left0 = 52;

        $display("[TB] draw request while busy");
        for (int n = 0; n < 3; n++) applyStimulus(1'b0);
        q0.push_back('{4, 0, cyc, cyc + 5});
        used0[3] = 1'b1;
        left0 = 48;
        p = pops0;
        bus0.draw_req = 1'b1;
        tick();
        checkOutput("overlap_busy", int'(bus0.busy), 1);
        tick();
        bus0.draw_req = 1'b0;
        waitPop0(p + 1);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("overlap_one_card", pops0, p + 1);
        checkOutput("overlap_cards_left", int'(bus0.cards_left), 48);

        $display("[TB] shuffle during probe");
        p = pops0;
        bus0.draw_req = 1'b1;
        tick();
        bus0.draw_req = 1'b0;
        checkOutput("probe_shuf_busy_before", int'(bus0.busy), 1);
        bus0.shuffle = 1'b1;
        tick();
        bus0.shuffle = 1'b0;
        checkOutput("probe_shuf_busy_after", int'(bus0.busy), 0);
        checkOutput("probe_shuf_cards_left", int'(bus0.cards_left), 52);
        tick();
        tick();
        tick();
        checkOutput("probe_shuf_no_card", pops0, p);
        used0 = '0;
        left0 = 52;

        $display("[TB] reset during probe");
        p = pops0;
        bus0.draw_req = 1'b1;
        tick();
        bus0.draw_req = 1'b0;
        checkOutput("probe_rst_busy_before", int'(bus0.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("probe_rst_busy", int'(bus0.busy), 0);
        checkOutput("probe_rst_cards_left", int'(bus0.cards_left), 52);
        checkOutput("probe_rst_value", int'(bus0.card_value), 0);
        checkOutput("probe_rst_symbol", int'(bus0.card_symbol), 0);
        checkOutput("probe_rst_valid", int'(bus0.card_valid), 0);
        tick();
        tick();
        checkOutput("probe_rst_no_card", pops0, p);

        $display("[TB] random deal of 52 cards");
        for (int n = 0; n < 52; n++) applyStimulus(1'b1);
        checkOutput("rand_distinct", $countones(seen1), 52);
        checkOutput("rand_deck_empty", int'(bus1.deck_empty), 1);
        checkOutput("rand_pending_left", q0.size() + q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
